// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - KANADE32 memory-access stage: data-memory handshake, branch resolution, writeback register
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_*                  execute/memory stage register fields; in_ready low stalls upstream
//   pc_src, pc_target     one-cycle PC redirect request and its target
//   flush                 one-cycle squash of younger stages, paired with pc_src
//   dmem_*                data-memory request/acknowledge interface (word addressed)
//   wb_*                  registered writeback fields; wb_valid pulses once per retired instruction
//   stall_cycles          saturating count of cycles spent with in_ready low
module mem_access_stage #(
  parameter int ADDR_W      = 30,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_next_pc,
  input  logic [31:0]            in_branch_pc,
  input  logic [31:0]            in_alu_result,
  input  logic [31:0]            in_store_data,
  input  logic [4:0]             in_wr_reg,
  input  logic                   in_dec_mem_to_reg,
  input  logic                   in_dec_reg_write,
  input  logic                   in_dec_mem_read,
  input  logic                   in_dec_mem_write,
  input  logic                   in_dec_branch,
  input  logic                   in_dec_jmp,
  input  logic                   in_alu_result_zero,
  output logic                   pc_src,
  output logic [31:0]            pc_target,
  output logic                   flush,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_W-1:0]      dmem_addr,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [31:0]            dmem_rdata,
  output logic                   wb_valid,
  output logic                   wb_reg_write,
  output logic [4:0]             wb_wr_reg,
  output logic [31:0]            wb_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_next;

  logic accept;
  logic ack_done;
  logic taken;
  logic mem_op;
  logic wr_enable;

  // Instruction fields that must survive the memory access.
  logic [4:0]  lat_wr_reg;
  logic        lat_mem_to_reg;
  logic        lat_reg_write;
  logic [31:0] lat_alu_result;

  // PC+4 has no consumer here; link values already travel through the ALU result.
  logic unused_next_pc;
  assign unused_next_pc = ^in_next_pc;

  assign taken     = in_dec_jmp | (in_dec_branch & in_alu_result_zero);
  // Control-flow instructions never touch memory even if a decode bit leaks through.
  assign mem_op    = (in_dec_mem_read | in_dec_mem_write) & ~in_dec_branch & ~in_dec_jmp;
  // r0 is hardwired to zero, so writes to it are dropped here.
  assign wr_enable = in_dec_reg_write & (in_wr_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    ack_done   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (mem_op) begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A stray ack in IDLE never reaches this branch, so it is ignored.
        if (dmem_ack) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_src         <= 1'b0;
      pc_target      <= 32'd0;
      flush          <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= 32'd0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_wr_reg      <= 5'd0;
      wb_data        <= 32'd0;
      stall_cycles   <= '0;
      lat_wr_reg     <= 5'd0;
      lat_mem_to_reg <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_alu_result <= 32'd0;
    end else begin
      pc_src   <= 1'b0;
      flush    <= 1'b0;
      wb_valid <= 1'b0;

      if (accept) begin
        if (taken) begin
          pc_src    <= 1'b1;
          flush     <= 1'b1;
          pc_target <= in_branch_pc;
        end
        if (mem_op) begin
          dmem_req       <= 1'b1;
          // Read wins when both read and write are decoded.
          dmem_we        <= in_dec_mem_write & ~in_dec_mem_read;
          dmem_addr      <= in_alu_result[ADDR_W+1:2];
          dmem_wdata     <= in_store_data;
          lat_wr_reg     <= in_wr_reg;
          lat_mem_to_reg <= in_dec_mem_to_reg;
          lat_reg_write  <= wr_enable;
          lat_alu_result <= in_alu_result;
        end else begin
          wb_valid     <= 1'b1;
          wb_reg_write <= wr_enable;
          wb_wr_reg    <= in_wr_reg;
          wb_data      <= in_alu_result;
        end
      end

      if (ack_done) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        wb_reg_write <= lat_reg_write;
        wb_wr_reg    <= lat_wr_reg;
        wb_data      <= lat_mem_to_reg ? dmem_rdata : lat_alu_result;
      end

      if (!in_ready && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_next_pc;
  logic [31:0] in_branch_pc;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_wr_reg;
  logic        in_dec_mem_to_reg;
  logic        in_dec_reg_write;
  logic        in_dec_mem_read;
  logic        in_dec_mem_write;
  logic        in_dec_branch;
  logic        in_dec_jmp;
  logic        in_alu_result_zero;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_wr_reg;
  logic [31:0] wb_data;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.ADDR_W(30), .STALL_CNT_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_next_pc         (in_next_pc),
    .in_branch_pc       (in_branch_pc),
    .in_alu_result      (in_alu_result),
    .in_store_data      (in_store_data),
    .in_wr_reg          (in_wr_reg),
    .in_dec_mem_to_reg  (in_dec_mem_to_reg),
    .in_dec_reg_write   (in_dec_reg_write),
    .in_dec_mem_read    (in_dec_mem_read),
    .in_dec_mem_write   (in_dec_mem_write),
    .in_dec_branch      (in_dec_branch),
    .in_dec_jmp         (in_dec_jmp),
    .in_alu_result_zero (in_alu_result_zero),
    .pc_src             (pc_src),
    .pc_target          (pc_target),
    .flush              (flush),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .wb_valid           (wb_valid),
    .wb_reg_write       (wb_reg_write),
    .wb_wr_reg          (wb_wr_reg),
    .wb_data            (wb_data),
    .stall_cycles       (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decode();
    in_valid           = 1'b0;
    in_dec_mem_to_reg  = 1'b0;
    in_dec_reg_write   = 1'b0;
    in_dec_mem_read    = 1'b0;
    in_dec_mem_write   = 1'b0;
    in_dec_branch      = 1'b0;
    in_dec_jmp         = 1'b0;
    in_alu_result_zero = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    in_next_pc    = 32'h0000_0004;
    in_branch_pc  = 32'd0;
    in_alu_result = 32'd0;
    in_store_data = 32'd0;
    in_wr_reg     = 5'd0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'd0;
    clear_decode();

    // Reset state
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_pc_src", {31'd0, pc_src}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_stall", {16'd0, stall_cycles}, 32'd0);
    reset = 1'b0;

    // Single ALU op
    in_valid = 1'b1; in_alu_result = 32'h0000_1234; in_wr_reg = 5'd5; in_dec_reg_write = 1'b1;
    tick();
    check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("alu_wb_wr_reg", {27'd0, wb_wr_reg}, 32'd5);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    check("alu_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    check("alu_pc_src", {31'd0, pc_src}, 32'd0);

    // Three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      in_alu_result = 32'h100 + i;
      in_wr_reg     = 5'(i + 1);
      tick();
      check("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("b2b_wb_data", wb_data, 32'h100 + i);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    end
    clear_decode();
    tick();
    check("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("idle_wb_data_hold", wb_data, 32'h0000_0102);

    // Load with three wait cycles, ack in fourth request cycle
    in_valid = 1'b1; in_alu_result = 32'h0000_0010; in_wr_reg = 5'd7;
    in_dec_mem_read = 1'b1; in_dec_mem_to_reg = 1'b1; in_dec_reg_write = 1'b1;
    tick();
    clear_decode();
    in_alu_result = 32'hFFFF_FFFF;
    check("ld_req", {31'd0, dmem_req}, 32'd1);
    check("ld_addr", {2'd0, dmem_addr}, 32'h4);
    check("ld_we", {31'd0, dmem_we}, 32'd0);
    check("ld_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_req_held", {31'd0, dmem_req}, 32'd1);
      check("ld_addr_held", {2'd0, dmem_addr}, 32'h4);
      check("ld_wait_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("ld_wait_in_ready", {31'd0, in_ready}, 32'd0);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    check("ld_req_drop", {31'd0, dmem_req}, 32'd0);
    check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    check("ld_wb_wr_reg", {27'd0, wb_wr_reg}, 32'd7);
    check("ld_wb_reg_write", {31'd0, wb_reg_write}, 32'd1);
    check("ld_in_ready", {31'd0, in_ready}, 32'd1);
    check("ld_stall", {16'd0, stall_cycles}, 32'd4);

    // Zero-wait store
    in_valid = 1'b1; in_alu_result = 32'h0000_0020; in_store_data = 32'hCAFE_F00D;
    in_wr_reg = 5'd0; in_dec_mem_write = 1'b1;
    tick();
    clear_decode();
    check("st_req", {31'd0, dmem_req}, 32'd1);
    check("st_we", {31'd0, dmem_we}, 32'd1);
    check("st_addr", {2'd0, dmem_addr}, 32'h8);
    check("st_wdata", dmem_wdata, 32'hCAFE_F00D);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("st_req_drop", {31'd0, dmem_req}, 32'd0);
    check("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("st_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    check("st_wb_data", wb_data, 32'h0000_0020);
    check("st_stall", {16'd0, stall_cycles}, 32'd5);

    // Stray ack while idle
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_ack = 1'b0;
    check("stray_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("stray_req", {31'd0, dmem_req}, 32'd0);
    check("stray_wb_data", wb_data, 32'h0000_0020);
    check("stray_in_ready", {31'd0, in_ready}, 32'd1);

    // Taken branch
    in_valid = 1'b1; in_dec_branch = 1'b1; in_alu_result_zero = 1'b1; in_branch_pc = 32'h0000_0100;
    in_alu_result = 32'd0;
    tick();
    clear_decode();
    check("br_pc_src", {31'd0, pc_src}, 32'd1);
    check("br_flush", {31'd0, flush}, 32'd1);
    check("br_target", pc_target, 32'h0000_0100);
    check("br_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("br_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    tick();
    check("br_pc_src_pulse", {31'd0, pc_src}, 32'd0);
    check("br_flush_pulse", {31'd0, flush}, 32'd0);
    check("br_target_hold", pc_target, 32'h0000_0100);

    // Not-taken branch
    in_valid = 1'b1; in_dec_branch = 1'b1; in_alu_result_zero = 1'b0; in_branch_pc = 32'h0000_0200;
    tick();
    clear_decode();
    check("bnt_pc_src", {31'd0, pc_src}, 32'd0);
    check("bnt_flush", {31'd0, flush}, 32'd0);
    check("bnt_target_hold", pc_target, 32'h0000_0100);

    // Jump with zero flag clear
    in_valid = 1'b1; in_dec_jmp = 1'b1; in_alu_result_zero = 1'b0; in_branch_pc = 32'h0000_0300;
    tick();
    clear_decode();
    check("jmp_pc_src", {31'd0, pc_src}, 32'd1);
    check("jmp_target", pc_target, 32'h0000_0300);
    check("jmp_req", {31'd0, dmem_req}, 32'd0);

    // Write to r0
    in_valid = 1'b1; in_alu_result = 32'h0000_0055; in_wr_reg = 5'd0; in_dec_reg_write = 1'b1;
    tick();
    clear_decode();
    check("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("r0_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    check("r0_wb_data", wb_data, 32'h0000_0055);

    // Read and write both decoded: load behaviour, low address bits ignored
    in_valid = 1'b1; in_alu_result = 32'h0000_0047; in_store_data = 32'h1111_2222; in_wr_reg = 5'd3;
    in_dec_mem_read = 1'b1; in_dec_mem_write = 1'b1; in_dec_mem_to_reg = 1'b1; in_dec_reg_write = 1'b1;
    tick();
    clear_decode();
    check("rw_we", {31'd0, dmem_we}, 32'd0);
    check("rw_addr", {2'd0, dmem_addr}, 32'h11);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    check("rw_wb_data", wb_data, 32'h1234_5678);
    check("rw_wb_wr_reg", {27'd0, wb_wr_reg}, 32'd3);
    check("rw_stall", {16'd0, stall_cycles}, 32'd6);

    // Reset during an access
    in_valid = 1'b1; in_alu_result = 32'h0000_0080; in_wr_reg = 5'd9;
    in_dec_mem_read = 1'b1; in_dec_mem_to_reg = 1'b1; in_dec_reg_write = 1'b1;
    tick();
    clear_decode();
    check("rst_acc_req", {31'd0, dmem_req}, 32'd1);
    tick();
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    tick();
    check("rst_acc_req_drop", {31'd0, dmem_req}, 32'd0);
    check("rst_acc_wb_valid", {31'd0, wb_valid}, 32'd0);
    reset = 1'b0; dmem_ack = 1'b0;
    tick();
    check("rst_acc_wb_valid_after", {31'd0, wb_valid}, 32'd0);
    check("rst_acc_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_acc_stall", {16'd0, stall_cycles}, 32'd0);
    check("rst_acc_wb_data", wb_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the KANADE32 pipeline, directly downstream of the execute/memory stage register. Consumes the latched ALU result, branch target and decoded control bits. Performs data-memory loads/stores over a req/ack handshake, stalling upstream while an access is outstanding. Resolves branches/jumps toward the PC and registers writeback results for the register file.

Parameters:
ADDR_W, 30, data-memory word-address width (byte address bits [31:2])
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  execute/memory stage register holds a valid instruction
in_ready  out  1  stage can accept this cycle; low = upstream must stall
in_next_pc  in  32  PC+4 of the instruction
in_branch_pc  in  32  branch/jump target computed in execute
in_alu_result  in  32  ALU result; also the byte address for loads/stores
in_store_data  in  32  store data (rt value)
in_wr_reg  in  5  destination register number
in_dec_mem_to_reg  in  1  writeback selects load data
in_dec_reg_write  in  1  instruction writes a register
in_dec_mem_read  in  1  load
in_dec_mem_write  in  1  store
in_dec_branch  in  1  conditional branch
in_dec_jmp  in  1  unconditional jump
in_alu_result_zero  in  1  ALU zero flag
pc_src  out  1  one-cycle pulse: redirect PC to pc_target
pc_target  out  32  redirect address
flush  out  1  one-cycle pulse with pc_src; squash younger stages
dmem_req  out  1  data-memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  ADDR_W  word address
dmem_wdata  out  32  store data
dmem_ack  in  1  memory completed request (load data valid same cycle)
dmem_rdata  in  32  load data
wb_valid  out  1  one-cycle pulse: writeback fields valid
wb_reg_write  out  1  writeback enable
wb_wr_reg  out  5  writeback register number
wb_data  out  32  writeback value
stall_cycles  out  STALL_CNT_W  saturating count of cycles with in_ready low

Behaviour:
- One clock; reset is synchronous and active-high. On reset: state IDLE, in_ready=1 on the following cycle, all other outputs 0, stall_cycles=0. Reset mid-access drops dmem_req at that edge; the pending access is abandoned and no wb_valid is produced.
- FSM states: IDLE, ACCESS.
- IDLE: in_ready=1. Accept when in_valid=1.
  - Non-memory op (mem_read=0, mem_write=0): next cycle wb_valid=1, wb_data=in_alu_result. 1-cycle latency; back-to-back accepts every cycle.
  - Memory op: latch all inputs. Next cycle dmem_req=1, dmem_addr=in_alu_result[31:2], dmem_we=mem_write, dmem_wdata=in_store_data. Go to ACCESS. in_ready=0.
  - mem_read and mem_write both set: treated as load; write ignored.
  - Address bits [1:0] ignored (no misalignment trap).
- ACCESS: dmem_req, dmem_we, dmem_addr, dmem_wdata held stable until dmem_ack sampled high. Ack is legal on the first req cycle (zero-wait memory gives 2-cycle total latency). On the ack edge: dmem_req=0, next cycle wb_valid=1, state IDLE, in_ready=1. wb_data = dmem_rdata captured on the ack edge if mem_to_reg, else the latched alu_result.
- dmem_ack while in IDLE: ignored.
- Writeback: wb_reg_write = reg_write AND (wr_reg != 0). wb_valid still pulses for stores and branches, with wb_reg_write=0. wb_wr_reg and wb_data hold their values between pulses.
- Branch resolution at accept: taken = jmp OR (branch AND alu_result_zero). If taken: pc_src=1, flush=1, pc_target=in_branch_pc for one cycle after accept. Otherwise pc_src=0 and pc_target holds its previous value. Branch/jump never access memory.
- stall_cycles increments every cycle in_ready=0. Saturates at all-ones.

Test Plan:
- ALU op alu_result=0x0000_1234, wr_reg=5, reg_write=1 -> next cycle wb_valid=1, wb_wr_reg=5, wb_data=0x1234, wb_reg_write=1. Three back-to-back ALU ops -> three consecutive wb_valid pulses, in_ready constantly 1.
- Load alu_result=0x0000_0010, mem_to_reg=1, memory acks after 3 cycles with rdata=0xDEAD_BEEF -> dmem_addr=0x4, dmem_we=0, req held 3 cycles, in_ready low 4 cycles, wb_data=0xDEADBEEF, stall_cycles=4.
- Store alu_result=0x20, store_data=0xCAFE_F00D, zero-wait ack -> dmem_we=1, dmem_addr=0x8, dmem_wdata=0xCAFEF00D, wb_valid=1 with wb_reg_write=0.
- Branch taken (branch=1, zero=1, branch_pc=0x100) -> pc_src=flush=1 for exactly one cycle, pc_target=0x100. Branch=1, zero=0 -> pc_src=0. jmp=1, zero=0 -> pc_src=1.
- Write to r0 (wr_reg=0, reg_write=1) -> wb_valid=1, wb_reg_write=0. Stray dmem_ack in IDLE -> no output change.
- Reset asserted during ACCESS -> dmem_req=0 after the edge, no wb_valid, in_ready=1 and stall_cycles=0 after release.
